// File: rtl/adc_paddle_tracker_pkg.sv
// Shared screen geometry and helpers for the paddle tracker.
// Default paddle travel limits are derived from the screen constants.
package adc_paddle_tracker_pkg;

    localparam int unsigned SCREEN_H = 480;
    localparam int unsigned BORDER   = 8;
    localparam int unsigned PADDLE_H = 64;

    // Paddle top edge may sit from just below the top border to PADDLE_H+BORDER above the bottom
    localparam int unsigned POS_MIN_DEF = BORDER;
    localparam int unsigned POS_MAX_DEF = SCREEN_H - PADDLE_H - BORDER;

    // Counter width that never collapses to zero bits
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/adc_sampler.sv
// ADC front end: divides pixel_clock into adc_clk, captures adc_d on the falling
// adc_clk transition and block-averages 2^AVG_LOG2 samples.
// Ports:
//   pixel_clock, reset  clock and synchronous active-high reset
//   adc_d               ADC parallel data
//   adc_clk             ADC sample clock (registered)
//   raw_sample          last captured sample
//   avg_valid           1-cycle flag, pos_raw_c holds a fresh block result
//   pos_raw_c           2x block mean (sum >> (AVG_LOG2-1))
module adc_sampler
    import adc_paddle_tracker_pkg::*;
#(
    parameter int unsigned ADC_W    = 8,
    parameter int unsigned AVG_LOG2 = 3,
    parameter int unsigned ADC_HALF = 1
) (
    input  logic             pixel_clock,
    input  logic             reset,
    input  logic [ADC_W-1:0] adc_d,
    output logic             adc_clk,
    output logic [ADC_W-1:0] raw_sample,
    output logic             avg_valid,
    output logic [ADC_W:0]   pos_raw_c
);

    localparam int unsigned DIV_W = clog2_min1(ADC_HALF);
    localparam int unsigned ACC_W = ADC_W + AVG_LOG2;
    localparam int unsigned CNT_W = AVG_LOG2;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(ADC_HALF - 1);

    logic [DIV_W-1:0] div;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             tc_c;
    logic             capture_c;

    assign tc_c      = (div == DIV_TC);
    // Capture on the cycle adc_clk is being driven 1->0
    assign capture_c = tc_c & adc_clk;

    // Divider, capture and block accumulation
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            div        <= '0;
            adc_clk    <= 1'b0;
            raw_sample <= '0;
            acc        <= '0;
            cnt        <= '0;
            sum        <= '0;
            avg_valid  <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (tc_c) begin
                div     <= '0;
                adc_clk <= ~adc_clk;
            end else begin
                div <= div + DIV_W'(1);
            end
            if (capture_c) begin
                raw_sample <= adc_d;
                if (&cnt) begin
                    // Last sample of the block: publish the sum, start a fresh block
                    sum       <= acc + ACC_W'(adc_d);
                    acc       <= '0;
                    cnt       <= '0;
                    avg_valid <= 1'b1;
                end else begin
                    acc <= acc + ACC_W'(adc_d);
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // Dividing by half the block length yields twice the mean
    assign pos_raw_c = (ADC_W + 1)'(sum >> (AVG_LOG2 - 1));

endmodule

// File: rtl/adc_paddle_tracker.sv
// Potentiometer paddle tracker: averaged ADC value is clamped to the playfield,
// filtered by a deadband and published only at frame boundaries.
// Ports:
//   pixel_clock, reset  clock and synchronous active-high reset
//   adc_d               ADC parallel data
//   frame_sync          vsync level; rising edge marks a frame boundary
//   adc_clk             ADC sample clock
//   paddle_y            published paddle Y, constant within a frame
//   paddle_upd          1-cycle pulse when paddle_y changes
//   raw_sample          last captured ADC sample
module adc_paddle_tracker
    import adc_paddle_tracker_pkg::*;
#(
    parameter int unsigned ADC_W    = 8,
    parameter int unsigned AVG_LOG2 = 3,
    parameter int unsigned ADC_HALF = 1,
    parameter int unsigned POS_W    = 11,
    parameter int unsigned POS_MIN  = POS_MIN_DEF,
    parameter int unsigned POS_MAX  = POS_MAX_DEF,
    parameter int unsigned DEADBAND = 2
) (
    input  logic             pixel_clock,
    input  logic             reset,
    input  logic [ADC_W-1:0] adc_d,
    input  logic             frame_sync,
    output logic             adc_clk,
    output logic [POS_W-1:0] paddle_y,
    output logic             paddle_upd,
    output logic [ADC_W-1:0] raw_sample
);

    localparam logic [POS_W-1:0] POS_MIN_V  = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] POS_MAX_V  = POS_W'(POS_MAX);
    localparam logic [POS_W:0]   DEADBAND_V = (POS_W + 1)'(DEADBAND);

    logic             avg_valid;
    logic [ADC_W:0]   pos_raw_c;
    logic [POS_W-1:0] pos_ext_c;
    logic [POS_W-1:0] pos_c;
    logic [POS_W-1:0] pending;
    logic [POS_W:0]   diff_c;
    logic             move_c;
    logic             frame_sync_d;
    logic             frame_edge_c;

    adc_sampler #(
        .ADC_W    (ADC_W),
        .AVG_LOG2 (AVG_LOG2),
        .ADC_HALF (ADC_HALF)
    ) u_sampler (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .adc_d       (adc_d),
        .adc_clk     (adc_clk),
        .raw_sample  (raw_sample),
        .avg_valid   (avg_valid),
        .pos_raw_c   (pos_raw_c)
    );

    assign pos_ext_c = POS_W'(pos_raw_c);

    // Clamp to the playfield and take |pos_c - pending|
    always_comb begin
        pos_c = pos_ext_c;
        if (pos_ext_c < POS_MIN_V) begin
            pos_c = POS_MIN_V;
        end else if (pos_ext_c > POS_MAX_V) begin
            pos_c = POS_MAX_V;
        end
        if (pos_c >= pending) begin
            diff_c = (POS_W + 1)'(pos_c) - (POS_W + 1)'(pending);
        end else begin
            diff_c = (POS_W + 1)'(pending) - (POS_W + 1)'(pos_c);
        end
    end

    assign move_c       = avg_valid & (diff_c > DEADBAND_V);
    assign frame_edge_c = frame_sync & ~frame_sync_d;

    // Pending update and frame-boundary publish; an edge coincident with a
    // pending update sees the old pending value
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            pending      <= POS_MIN_V;
            frame_sync_d <= 1'b0;
            paddle_y     <= POS_MIN_V;
            paddle_upd   <= 1'b0;
        end else begin
            frame_sync_d <= frame_sync;
            paddle_upd   <= 1'b0;
            if (move_c) begin
                pending <= pos_c;
            end
            if (frame_edge_c) begin
                paddle_y   <= pending;
                paddle_upd <= (pending != paddle_y);
            end
        end
    end

endmodule

// File: tb/tb_adc_paddle_tracker.sv
// Directed bench for adc_paddle_tracker with default parameters (ADC_HALF=1:
// one capture every 2 cycles, one block every 16 cycles after reset release).
module tb_adc_paddle_tracker;

    logic        pixel_clock;
    logic        reset;
    logic [7:0]  adc_d;
    logic        frame_sync;
    logic        adc_clk;
    logic [10:0] paddle_y;
    logic        paddle_upd;
    logic [7:0]  raw_sample;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    adc_paddle_tracker dut (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .adc_d       (adc_d),
        .frame_sync  (frame_sync),
        .adc_clk     (adc_clk),
        .paddle_y    (paddle_y),
        .paddle_upd  (paddle_upd),
        .raw_sample  (raw_sample)
    );

    initial pixel_clock = 1'b0;
    always #5 pixel_clock = ~pixel_clock;

    // Cycles since the last reset edge; blocks complete when cyc is a multiple of 16
    always @(posedge pixel_clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Wait for a block boundary, then hold val for one whole block; returns
    // one cycle after the block completes, when pending has been updated
    task automatic run_block(input logic [7:0] val);
        int guard;
        guard = 0;
        while ((cyc % 16) != 0 && guard < 20) begin
            @(posedge pixel_clock); #1;
            guard++;
        end
        total++;
        if ((cyc % 16) != 0) begin
            bad++;
            $display("FAIL align: cyc=%0d not on a block boundary", cyc);
        end
        adc_d = val;
        repeat (17) @(posedge pixel_clock);
        #1;
    endtask

    // Single frame_sync pulse held for two cycles
    task automatic frame_pulse(input logic [10:0] exp_y, input logic exp_upd, input string tag);
        frame_sync = 1'b1;
        @(posedge pixel_clock); #1;
        total++;
        if (paddle_y !== exp_y) begin
            bad++;
            $display("FAIL %s paddle_y: got %0d want %0d", tag, paddle_y, exp_y);
        end
        total++;
        if (paddle_upd !== exp_upd) begin
            bad++;
            $display("FAIL %s paddle_upd: got %b want %b", tag, paddle_upd, exp_upd);
        end
        @(posedge pixel_clock); #1;
        total++;
        if (paddle_upd !== 1'b0) begin
            bad++;
            $display("FAIL %s upd_width: got %b want 0", tag, paddle_upd);
        end
        frame_sync = 1'b0;
        @(posedge pixel_clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge pixel_clock);
        #1;
        total++;
        if (adc_clk !== 1'b0) begin bad++; $display("FAIL reset adc_clk: got %b want 0", adc_clk); end
        total++;
        if (paddle_y !== 11'd8) begin bad++; $display("FAIL reset paddle_y: got %0d want 8", paddle_y); end
        total++;
        if (paddle_upd !== 1'b0) begin bad++; $display("FAIL reset paddle_upd: got %b want 0", paddle_upd); end
        total++;
        if (raw_sample !== 8'd0) begin bad++; $display("FAIL reset raw_sample: got %0d want 0", raw_sample); end
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge pixel_clock); #1;
            total++;
            if (adc_clk !== 1'(i % 2)) begin
                bad++;
                $display("FAIL adc_clk_toggle[%0d]: got %b want %b", i, adc_clk, 1'(i % 2));
            end
        end
    endtask

    task automatic test_basic();
        run_block(8'd100);
        total++;
        if (raw_sample !== 8'd100) begin bad++; $display("FAIL basic raw_sample: got %0d want 100", raw_sample); end
        total++;
        if (paddle_y !== 11'd8) begin bad++; $display("FAIL basic pre_edge paddle_y: got %0d want 8", paddle_y); end
        frame_pulse(11'd200, 1'b1, "basic");
    endtask

    task automatic test_clamp();
        run_block(8'd0);
        frame_pulse(11'd8, 1'b1, "clamp_low");
        run_block(8'd0);
        frame_pulse(11'd8, 1'b0, "clamp_low_hold");
        run_block(8'd255);
        total++;
        if (raw_sample !== 8'd255) begin bad++; $display("FAIL clamp raw_sample: got %0d want 255", raw_sample); end
        frame_pulse(11'd408, 1'b1, "clamp_high");
    endtask

    task automatic test_deadband();
        run_block(8'd100);
        frame_pulse(11'd200, 1'b1, "db_base");
        run_block(8'd101);
        frame_pulse(11'd200, 1'b0, "db_within");
        run_block(8'd102);
        frame_pulse(11'd204, 1'b1, "db_exceed");
    endtask

    // Frame edge lands on the same cycle pending takes 300
    task automatic test_coincident();
        int guard;
        guard = 0;
        while ((cyc % 16) != 0 && guard < 20) begin
            @(posedge pixel_clock); #1;
            guard++;
        end
        adc_d = 8'd150;
        repeat (16) @(posedge pixel_clock);
        #1;
        frame_sync = 1'b1;
        @(posedge pixel_clock); #1;
        total++;
        if (paddle_y !== 11'd204) begin bad++; $display("FAIL coincident paddle_y: got %0d want 204", paddle_y); end
        total++;
        if (paddle_upd !== 1'b0) begin bad++; $display("FAIL coincident paddle_upd: got %b want 0", paddle_upd); end
        @(posedge pixel_clock); #1;
        frame_sync = 1'b0;
        @(posedge pixel_clock); #1;
        frame_pulse(11'd300, 1'b1, "coincident_next");
    endtask

    task automatic test_long_frame();
        int ups;
        run_block(8'd50);
        ups = 0;
        frame_sync = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge pixel_clock); #1;
            if (paddle_upd === 1'b1) ups++;
        end
        total++;
        if (ups != 1) begin bad++; $display("FAIL long_frame upd_count: got %0d want 1", ups); end
        total++;
        if (paddle_y !== 11'd100) begin bad++; $display("FAIL long_frame paddle_y: got %0d want 100", paddle_y); end
        frame_sync = 1'b0;
        @(posedge pixel_clock); #1;
    endtask

    // Five samples of 200 are discarded by reset; only fresh 50s may count
    task automatic test_reset_mid();
        int guard;
        run_block(8'd200);
        guard = 0;
        while ((cyc % 16) != 0 && guard < 20) begin
            @(posedge pixel_clock); #1;
            guard++;
        end
        adc_d = 8'd200;
        repeat (10) @(posedge pixel_clock);
        #1;
        reset = 1'b1;
        @(posedge pixel_clock); #1;
        reset = 1'b0;
        total++;
        if (paddle_y !== 11'd8) begin bad++; $display("FAIL reset_mid paddle_y: got %0d want 8", paddle_y); end
        adc_d = 8'd50;
        frame_sync = 1'b1;
        @(posedge pixel_clock); #1;
        total++;
        if (paddle_y !== 11'd8 || paddle_upd !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid early_edge: got y=%0d upd=%b want y=8 upd=0", paddle_y, paddle_upd);
        end
        frame_sync = 1'b0;
        guard = 0;
        while (cyc != 17 && guard < 40) begin
            @(posedge pixel_clock); #1;
            guard++;
        end
        total++;
        if (paddle_y !== 11'd8) begin bad++; $display("FAIL reset_mid pre_edge paddle_y: got %0d want 8", paddle_y); end
        frame_sync = 1'b1;
        @(posedge pixel_clock); #1;
        total++;
        if (paddle_y !== 11'd100) begin bad++; $display("FAIL reset_mid paddle_y: got %0d want 100", paddle_y); end
        total++;
        if (paddle_upd !== 1'b1) begin bad++; $display("FAIL reset_mid paddle_upd: got %b want 1", paddle_upd); end
        frame_sync = 1'b0;
        @(posedge pixel_clock); #1;
    endtask

    initial begin
        reset      = 1'b1;
        adc_d      = 8'd0;
        frame_sync = 1'b0;
        test_reset();
        test_basic();
        test_clamp();
        test_deadband();
        test_coincident();
        test_long_frame();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
